// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: per-source FIFOs for the ALU and LSB writeback paths, drained
// round-robin onto a registered CDB. A RoB clear flushes everything in flight.
module cdb_arbiter #(
    parameter int ROB_ID_W = 4,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                clear,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [31:0]         alu_value,
    output logic                alu_full,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [31:0]         lsb_value,
    output logic                lsb_full,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [31:0]         cdb_value,
    output logic                cdb_src
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ROB_ID_W + 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    logic [ENT_W-1:0]    mem_q [2][DEPTH];
    logic [ENT_W-1:0]    mem_d [2][DEPTH];
    logic [PTR_W-1:0]    wptr_q [2];
    logic [PTR_W-1:0]    wptr_d [2];
    logic [PTR_W-1:0]    rptr_q [2];
    logic [PTR_W-1:0]    rptr_d [2];
    logic [CNT_W-1:0]    cnt_q  [2];
    logic [CNT_W-1:0]    cnt_d  [2];
    src_e                last_grant_q, last_grant_d;
    logic                cdb_valid_q, cdb_valid_d;
    logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [31:0]         cdb_value_q, cdb_value_d;
    src_e                cdb_src_q, cdb_src_d;

    logic [1:0]          in_valid;
    logic [ENT_W-1:0]    in_ent [2];
    logic [1:0]          full;
    logic [1:0]          nonempty;
    logic [1:0]          push;
    logic [1:0]          pop;
    logic                any;
    src_e                grant;
    logic                gidx;

    assign in_valid  = {lsb_valid, alu_valid};
    assign in_ent[0] = {alu_rob_id, alu_value};
    assign in_ent[1] = {lsb_rob_id, lsb_value};

    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            full[s]     = (cnt_q[s] == CNT_W'(DEPTH));
            nonempty[s] = (cnt_q[s] != '0);
        end
    end

    // Arbitration sees only the pre-edge FIFO contents, so same-edge pushes never win.
    always_comb begin
        any   = |nonempty;
        grant = SRC_ALU;
        if (&nonempty) begin
            grant = (last_grant_q == SRC_LSB) ? SRC_ALU : SRC_LSB;
        end else if (nonempty[1]) begin
            grant = SRC_LSB;
        end
        gidx = (grant == SRC_LSB);
    end

    always_comb begin
        mem_d        = mem_q;
        last_grant_d = last_grant_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_value_d  = cdb_value_q;
        cdb_src_d    = cdb_src_q;
        push         = '0;
        pop          = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            wptr_d[s] = wptr_q[s];
            rptr_d[s] = rptr_q[s];
            cnt_d[s]  = cnt_q[s];
        end

        if (rdy) begin
            if (clear) begin
                for (int unsigned s = 0; s < 2; s++) begin
                    wptr_d[s] = '0;
                    rptr_d[s] = '0;
                    cnt_d[s]  = '0;
                end
                cdb_valid_d  = 1'b0;
                last_grant_d = SRC_LSB;
            end else begin
                // Full is judged on the registered count, so a full FIFO refuses a push even while popping.
                push    = in_valid & ~full;
                pop[0]  = any && (grant == SRC_ALU);
                pop[1]  = any && (grant == SRC_LSB);
                for (int unsigned s = 0; s < 2; s++) begin
                    if (push[s]) begin
                        mem_d[s][wptr_q[s]] = in_ent[s];
                        wptr_d[s] = wptr_q[s] + PTR_W'(1);
                    end
                    if (pop[s]) begin
                        rptr_d[s] = rptr_q[s] + PTR_W'(1);
                    end
                    cnt_d[s] = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
                end
                cdb_valid_d = any;
                if (any) begin
                    {cdb_rob_id_d, cdb_value_d} = mem_q[gidx][rptr_q[gidx]];
                    cdb_src_d    = grant;
                    last_grant_d = grant;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < 2; s++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_q[s][i] <= '0;
                end
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            last_grant_q <= SRC_LSB;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= SRC_ALU;
        end else begin
            mem_q        <= mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_value_q  <= cdb_value_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign alu_full   = full[0];
    assign lsb_full   = full[1];
    assign cdb_valid  = cdb_valid_q;
    assign cdb_rob_id = cdb_rob_id_q;
    assign cdb_value  = cdb_value_q;
    assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin order, backpressure,
// flush, stall and asynchronous reset, with hand-computed expectations.
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        clear;
    logic        alu_valid;
    logic [3:0]  alu_rob_id;
    logic [31:0] alu_value;
    logic        alu_full;
    logic        lsb_valid;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic        lsb_full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        cdb_src;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.ROB_ID_W(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (rdy),
        .clear      (clear),
        .alu_valid  (alu_valid),
        .alu_rob_id (alu_rob_id),
        .alu_value  (alu_value),
        .alu_full   (alu_full),
        .lsb_valid  (lsb_valid),
        .lsb_rob_id (lsb_rob_id),
        .lsb_value  (lsb_value),
        .lsb_full   (lsb_full),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_src    (cdb_src)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        rdy = 1'b1; clear = 1'b0;
        alu_valid = 1'b0; alu_rob_id = '0; alu_value = '0;
        lsb_valid = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    endtask

    task automatic drv_alu(input logic [3:0] id);
        alu_valid = 1'b1; alu_rob_id = id; alu_value = 32'h1000 + 32'(id);
    endtask

    task automatic drv_lsb(input logic [3:0] id);
        lsb_valid = 1'b1; lsb_rob_id = id; lsb_value = 32'h2000 + 32'(id);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step(); step();
        @(negedge clk);
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", cdb_valid); end
        checks++; if (cdb_rob_id !== 4'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", cdb_rob_id); end
        checks++; if (cdb_value !== 32'd0) begin errors++; $display("FAIL reset_value: got %0h expected 0", cdb_value); end
        checks++; if (cdb_src !== 1'b0) begin errors++; $display("FAIL reset_src: got %0b expected 0", cdb_src); end
        checks++; if (alu_full !== 1'b0) begin errors++; $display("FAIL reset_alu_full: got %0b expected 0", alu_full); end
        checks++; if (lsb_full !== 1'b0) begin errors++; $display("FAIL reset_lsb_full: got %0b expected 0", lsb_full); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic ev [5] = '{0, 0, 1, 0, 0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0) begin
                alu_valid = 1'b1; alu_rob_id = 4'd3; alu_value = 32'h1234;
            end
            @(negedge clk);
            checks++;
            if (cdb_valid !== ev[c]) begin errors++; $display("FAIL single_valid c%0d: got %0b expected %0b", c, cdb_valid, ev[c]); end
            if (ev[c]) begin
                checks++;
                if (cdb_rob_id !== 4'd3 || cdb_value !== 32'h1234 || cdb_src !== 1'b0) begin
                    errors++;
                    $display("FAIL single_data c%0d: got id=%0d val=%0h src=%0b expected id=3 val=1234 src=0", c, cdb_rob_id, cdb_value, cdb_src);
                end
            end
            step();
        end
    endtask

    task automatic test_contention();
        logic       ev [7] = '{0, 0, 1, 1, 1, 1, 0};
        logic [3:0] eid [7] = '{0, 0, 1, 5, 2, 6, 0};
        logic       es [7] = '{0, 0, 0, 1, 0, 1, 0};
        logic [31:0] evl;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c == 0) begin drv_alu(4'd1); drv_lsb(4'd5); end
            if (c == 1) begin drv_alu(4'd2); drv_lsb(4'd6); end
            @(negedge clk);
            checks++;
            if (cdb_valid !== ev[c]) begin errors++; $display("FAIL contention_valid c%0d: got %0b expected %0b", c, cdb_valid, ev[c]); end
            if (ev[c]) begin
                evl = (es[c] ? 32'h2000 : 32'h1000) + 32'(eid[c]);
                checks++;
                if (cdb_rob_id !== eid[c] || cdb_src !== es[c] || cdb_value !== evl) begin
                    errors++;
                    $display("FAIL contention_data c%0d: got id=%0d src=%0b val=%0h expected id=%0d src=%0b val=%0h", c, cdb_rob_id, cdb_src, cdb_value, eid[c], es[c], evl);
                end
            end
            step();
        end
    endtask

    task automatic test_full();
        logic       ev [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
        logic [3:0] eid [8] = '{0, 0, 10, 7, 11, 8, 12, 0};
        logic       es [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
        logic       elf [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        logic       eaf [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c == 0) begin drv_alu(4'd10); drv_lsb(4'd7); end
            if (c == 1) begin drv_alu(4'd11); drv_lsb(4'd8); end
            if (c == 2) begin drv_alu(4'd12); drv_lsb(4'd9); end
            @(negedge clk);
            checks++;
            if (lsb_full !== elf[c]) begin errors++; $display("FAIL full_lsb_full c%0d: got %0b expected %0b", c, lsb_full, elf[c]); end
            checks++;
            if (alu_full !== eaf[c]) begin errors++; $display("FAIL full_alu_full c%0d: got %0b expected %0b", c, alu_full, eaf[c]); end
            checks++;
            if (cdb_valid !== ev[c]) begin errors++; $display("FAIL full_valid c%0d: got %0b expected %0b", c, cdb_valid, ev[c]); end
            if (ev[c]) begin
                checks++;
                if (cdb_rob_id !== eid[c] || cdb_src !== es[c]) begin
                    errors++;
                    $display("FAIL full_data c%0d: got id=%0d src=%0b expected id=%0d src=%0b", c, cdb_rob_id, cdb_src, eid[c], es[c]);
                end
            end
            step();
        end
    endtask

    task automatic test_flush();
        logic       ev [10] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
        logic [3:0] eid [10] = '{0, 0, 1, 0, 0, 0, 0, 11, 12, 0};
        logic       es [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c == 0) begin drv_alu(4'd1); drv_lsb(4'd3); end
            if (c == 1) begin drv_alu(4'd2); drv_lsb(4'd4); end
            if (c == 2) begin clear = 1'b1; drv_alu(4'd9); end
            if (c == 5) begin drv_alu(4'd11); drv_lsb(4'd12); end
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (lsb_full !== 1'b1) begin errors++; $display("FAIL flush_prefull c%0d: got %0b expected 1", c, lsb_full); end
            end
            if (c == 3) begin
                checks++;
                if (alu_full !== 1'b0 || lsb_full !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_fulls c%0d: got alu=%0b lsb=%0b expected 0 0", c, alu_full, lsb_full);
                end
            end
            checks++;
            if (cdb_valid !== ev[c]) begin errors++; $display("FAIL flush_valid c%0d: got %0b expected %0b", c, cdb_valid, ev[c]); end
            if (ev[c]) begin
                checks++;
                if (cdb_rob_id !== eid[c] || cdb_src !== es[c]) begin
                    errors++;
                    $display("FAIL flush_data c%0d: got id=%0d src=%0b expected id=%0d src=%0b", c, cdb_rob_id, cdb_src, eid[c], es[c]);
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic       ev [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
        logic [3:0] eid [8] = '{0, 0, 4, 4, 4, 4, 5, 0};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c == 0) drv_alu(4'd4);
            if (c == 1) drv_alu(4'd5);
            if (c >= 2 && c <= 4) begin rdy = 1'b0; drv_alu(4'd6); end
            @(negedge clk);
            checks++;
            if (cdb_valid !== ev[c]) begin errors++; $display("FAIL stall_valid c%0d: got %0b expected %0b", c, cdb_valid, ev[c]); end
            if (ev[c]) begin
                checks++;
                if (cdb_rob_id !== eid[c] || cdb_src !== 1'b0 || cdb_value !== 32'h1000 + 32'(eid[c])) begin
                    errors++;
                    $display("FAIL stall_data c%0d: got id=%0d src=%0b val=%0h expected id=%0d src=0", c, cdb_rob_id, cdb_src, cdb_value, eid[c]);
                end
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        logic       ev [4] = '{0, 1, 1, 0};
        logic [3:0] eid [4] = '{0, 7, 8, 0};
        logic       es [4] = '{0, 0, 1, 0};
        do_reset();
        drv_alu(4'd1); drv_lsb(4'd3);
        step();
        idle(); drv_alu(4'd2); drv_lsb(4'd4);
        step();
        idle();
        #2;
        checks++;
        if (cdb_valid !== 1'b1 || lsb_full !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got valid=%0b lsb_full=%0b expected 1 1", cdb_valid, lsb_full);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_rob_id !== 4'd0) begin
            errors++;
            $display("FAIL areset_cdb: got valid=%0b id=%0d expected 0 0", cdb_valid, cdb_rob_id);
        end
        checks++;
        if (alu_full !== 1'b0 || lsb_full !== 1'b0) begin
            errors++;
            $display("FAIL areset_fulls: got alu=%0b lsb=%0b expected 0 0", alu_full, lsb_full);
        end
        drv_alu(4'd7); drv_lsb(4'd8);
        #1;
        rst_n = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            idle();
            @(negedge clk);
            checks++;
            if (cdb_valid !== ev[c]) begin errors++; $display("FAIL areset_valid c%0d: got %0b expected %0b", c, cdb_valid, ev[c]); end
            if (ev[c]) begin
                checks++;
                if (cdb_rob_id !== eid[c] || cdb_src !== es[c]) begin
                    errors++;
                    $display("FAIL areset_data c%0d: got id=%0d src=%0b expected id=%0d src=%0b", c, cdb_rob_id, cdb_src, eid[c], es[c]);
                end
            end
            step();
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_flush();
        test_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single result broadcast bus (CDB) between the two execution-side producers, the ALU reservation station and the load/store buffer. These are the two writeback sources the reorder buffer accepts. Each source feeds a small private FIFO. A round-robin arbiter pops at most one entry per cycle onto a registered CDB, which drives the RoB's completion port and the RS/LSB wakeup logic. A RoB `clear` (branch mispredict) flushes everything in flight.

## Interface
- `ROB_ID_W`, default 4: RoB index width; equals `ROB_SIZE_WIDTH` from config.v.
- `DEPTH`, default 2: entries per source FIFO; must be a power of two, ≥ 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rdy`  in  1  global enable; when 0, all state holds.
- `clear`  in  1  flush request from the RoB; acted on only when `rdy`=1.
- `alu_valid`  in  1  ALU result offered this cycle.
- `alu_rob_id`  in  ROB_ID_W  destination RoB entry of the ALU result.
- `alu_value`  in  32  ALU result value.
- `alu_full`  out  1  ALU FIFO holds `DEPTH` entries (combinational from the count register).
- `lsb_valid`  in  1  LSB result offered this cycle.
- `lsb_rob_id`  in  ROB_ID_W  destination RoB entry of the LSB result.
- `lsb_value`  in  32  LSB result value.
- `lsb_full`  out  1  LSB FIFO holds `DEPTH` entries.
- `cdb_valid`  out  1  broadcast valid; registered.
- `cdb_rob_id`  out  ROB_ID_W  broadcast RoB id; registered.
- `cdb_value`  out  32  broadcast value; registered.
- `cdb_src`  out  1  source of the broadcast: 0 = ALU, 1 = LSB; registered.

## Operation
- Each source has a circular FIFO.
  - `DEPTH` entries, each {rob_id, value}.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - The count register is log2(DEPTH)+1 bits.
- Push: `src_valid` && !`src_full` at the edge writes to the tail.
  - `src_valid` while full is ignored; the entry is dropped. Producers must stall on `src_full`.
  - Full is evaluated before any same-cycle pop. A full FIFO therefore rejects a push even when it is popped in the same cycle.
- Arbitration happens once per edge and looks only at FIFO contents before this edge's pushes.
  - Only one FIFO non-empty: grant it.
  - Both FIFOs non-empty: grant the source not granted most recently (`last_grant` register).
  - The grant pops that FIFO's head into the `cdb_*` registers, sets `cdb_valid`=1 and updates `last_grant`.
  - Both FIFOs empty: `cdb_valid`←0. `cdb_rob_id`, `cdb_value` and `cdb_src` hold their values.
- Push and pop on the same FIFO in the same edge: the count is unchanged and both pointers advance.
- Clear (`rdy`=1 && `clear`=1):
  - Both FIFOs empty: pointers and counts go to 0.
  - `cdb_valid`←0.
  - `last_grant`←LSB.
  - Pushes offered that cycle are dropped.
  - Clear takes priority over push and pop.
- `rdy`=0: nothing changes, including `cdb_valid`. The consumers are also frozen, so a held broadcast is not double-counted.
- Reset (`rst_n`=0, asynchronous, effective at any point mid-operation):
  - Pointers and counts go to 0.
  - `cdb_valid`=0, `cdb_rob_id`=0, `cdb_value`=0, `cdb_src`=0.
  - `last_grant`=LSB, so the ALU wins the first tie.
  - `alu_full`=0 and `lsb_full`=0.

## Timing
- Push to broadcast is 2 cycles minimum. A value offered in cycle 0 is captured at edge 1, popped at edge 2, and `cdb_valid` is high during cycle 2.
- `cdb_valid` lasts exactly one cycle per popped entry, with `rdy` continuously 1.
- Throughput is 1 broadcast per cycle total. Under sustained contention each source gets alternate cycles.
- `src_full` reflects the count after the previous edge. A producer that sees `full`=0 may push this cycle.
- Reset release: the first push is accepted at the first rising edge with `rst_n`=1.

## Test plan
- Single ALU result:
  - Stimulus: `alu_valid`=1, id=3, value=0x1234 in cycle 0 only.
  - Required: `cdb_valid`=1, id=3, value=0x1234, src=0 in cycle 2 only; `cdb_valid`=0 from cycle 3.
- Contention:
  - Stimulus: ALU ids 1, 2 and LSB ids 5, 6 pushed together in cycles 0–1.
  - Required broadcast order in cycles 2–5: 1 (ALU), 5 (LSB), 2 (ALU), 6 (LSB).
- Full/backpressure with `DEPTH`=2:
  - Stimulus: push LSB ids 7, 8, 9 on consecutive cycles while the ALU FIFO is kept non-empty with tie-winning entries.
  - Required: `lsb_full`=1 after the second capture and id 9 is dropped. The CDB never shows id 9.
- Flush:
  - Stimulus: fill both FIFOs, then assert `clear` for one cycle.
  - Required: `cdb_valid`=0 next cycle; no stale ids are broadcast afterwards; `alu_full`=0 and `lsb_full`=0.
- Stall:
  - Stimulus: `rdy`=0 for 3 cycles while a broadcast of id 4 is live.
  - Required: `cdb_*` hold id 4 and FIFO counts stay unchanged. After `rdy` returns to 1, the next entry follows one cycle later.
- Async reset:
  - Stimulus: pull `rst_n` low between clock edges while FIFOs are non-empty.
  - Required: `cdb_valid`=0 and both full flags=0 immediately, before the next edge. After release, the first tie goes to the ALU.
